// File: rtl/vga_image_mux_if.sv
// vga_image_mux_if: video, palette and colour signals
// between the timing generator, frame buffer and VGA pins.
interface vga_image_mux_if #(
  parameter int CHANNELS   = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 6
);
  logic                           i_pix_stb;
  logic                           i_active;
  logic                           i_frame;
  logic [SEL_WIDTH-1:0]           i_sel;
  logic                           i_fade_en;
  logic                           i_pal_we;
  logic [SEL_WIDTH-1:0]           i_pal_ch;
  logic [DATA_WIDTH-1:0]          i_pal_addr;
  logic [11:0]                    i_pal_data;
  logic [CHANNELS*DATA_WIDTH-1:0] i_pix_data;
  logic [ADDR_WIDTH-1:0]          o_addr;
  logic [3:0]                     o_r;
  logic [3:0]                     o_g;
  logic [3:0]                     o_b;
  logic [SEL_WIDTH-1:0]           o_cur_sel;
  logic                           o_busy;

  modport master (
    output i_pix_stb, i_active, i_frame,
    output i_sel, i_fade_en,
    output i_pal_we, i_pal_ch,
    output i_pal_addr, i_pal_data,
    output i_pix_data,
    input  o_addr, o_r, o_g, o_b,
    input  o_cur_sel, o_busy
  );

  modport slave (
    input  i_pix_stb, i_active, i_frame,
    input  i_sel, i_fade_en,
    input  i_pal_we, i_pal_ch,
    input  i_pal_addr, i_pal_data,
    input  i_pix_data,
    output o_addr, o_r, o_g, o_b,
    output o_cur_sel, o_busy
  );
endinterface

// File: rtl/vga_image_mux.sv
// vga_image_mux: N-channel frame-buffer selector with
// per-channel palettes and frame-aligned fade switching.
module vga_image_mux #(
  parameter int CHANNELS   = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 230400,
  parameter int FADE_STEP  = 1
) (
  input logic            i_clk,
  input logic            i_rst,
  vga_image_mux_if.slave bus
);

  localparam int PAL_N  = CHANNELS << DATA_WIDTH;
  localparam int PAL_AW = SEL_WIDTH + DATA_WIDTH;
  localparam logic [4:0] LSTEP = 5'(FADE_STEP);
  localparam logic [4:0] FULL  = 5'd16;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } state_t;

  state_t                state;
  logic [4:0]            level;
  logic [SEL_WIDTH-1:0]  cur_sel;
  logic [SEL_WIDTH-1:0]  pending;
  logic [ADDR_WIDTH-1:0] addr;
  logic [11:0]           pal [PAL_N];
  logic [11:0]           pal_q;
  logic [1:0]            act_q;
  logic [3:0]            r_q;
  logic [3:0]            g_q;
  logic [3:0]            b_q;
  logic [DATA_WIDTH-1:0] pix;
  logic                  pal_wr_ok;
  logic                  sel_ok;
  logic [PAL_AW-1:0]     wr_idx;
  logic [PAL_AW-1:0]     rd_idx;

  function automatic logic [3:0] scale(
    input logic [3:0] c,
    input logic [4:0] lv
  );
    logic [8:0] p;
    p = 9'(c) * 9'(lv);
    return 4'(p >> 4);
  endfunction

  assign pix = bus.i_pix_data[
    int'(cur_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign pal_wr_ok = bus.i_pal_we &&
    (int'(bus.i_pal_ch) < CHANNELS);
  assign sel_ok = int'(bus.i_sel) < CHANNELS;
  assign wr_idx = {bus.i_pal_ch, bus.i_pal_addr};
  assign rd_idx = {cur_sel, pix};

  // Read address: cleared each frame, steps per visible pixel
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr <= '0;
    end else if (bus.i_frame) begin
      addr <= '0;
    end else if (bus.i_pix_stb && bus.i_active) begin
      addr <= (addr == LAST) ? '0 : addr + 1'b1;
    end
  end

  // Palette write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (pal_wr_ok) begin
      pal[wr_idx] <= bus.i_pal_data;
    end
  end

  // Registered palette lookup (old data on collision)
  always_ff @(posedge i_clk) begin
    pal_q <= pal[rd_idx];
  end

  // Active delay and faded colour output stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      act_q <= {act_q[0], bus.i_active};
      if (act_q[1]) begin
        r_q <= scale(pal_q[11:8], level);
        g_q <= scale(pal_q[7:4], level);
        b_q <= scale(pal_q[3:0], level);
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  // Channel select FSM, advances only on frame pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      level   <= FULL;
      cur_sel <= '0;
      pending <= '0;
    end else if (bus.i_frame) begin
      unique case (state)
        IDLE: begin
          if (bus.i_sel != cur_sel && sel_ok) begin
            if (bus.i_fade_en) begin
              pending <= bus.i_sel;
              state   <= FADE_OUT;
            end else begin
              cur_sel <= bus.i_sel;
            end
          end
        end
        FADE_OUT: begin
          level <= level - LSTEP;
          if (level == LSTEP) begin
            cur_sel <= pending;
            state   <= FADE_IN;
          end
        end
        FADE_IN: begin
          level <= level + LSTEP;
          if (level == FULL - LSTEP) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_addr    = addr;
  assign bus.o_r       = r_q;
  assign bus.o_g       = g_q;
  assign bus.o_b       = b_q;
  assign bus.o_cur_sel = cur_sel;
  assign bus.o_busy    = (state != IDLE);

endmodule
